// File: rtl/bht_predictor.sv
// Global-history (gshare) branch predictor: a table of saturating counters indexed by
// pc XOR history, with registered predictions and update/hit statistics.
module bht_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int HIST_BITS  = 4,
  parameter int CTR_BITS   = 2,
  parameter int INIT_CTR   = 1,
  parameter int STAT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  request,
  input  logic [INDEX_BITS-1:0] req_pc,
  output logic                  pred_valid,
  output logic                  prediction,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  update,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  taken,
  output logic [STAT_BITS-1:0]  upd_count,
  output logic [STAT_BITS-1:0]  hit_count
);

  localparam int unsigned DEPTH = 2 ** INDEX_BITS;
  // One spare bit keeps the history register legal when HIST_BITS is zero; it then stays 0.
  localparam int GW = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic [CTR_BITS-1:0]   tbl_q [DEPTH];
  logic [GW-1:0]         ghr_q, ghr_d;
  logic [STAT_BITS-1:0]  upd_count_q, upd_count_d;
  logic [STAT_BITS-1:0]  hit_count_q, hit_count_d;
  logic                  pred_valid_q;
  logic                  prediction_q, prediction_d;
  logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;

  logic [INDEX_BITS-1:0] hist_ext;
  logic [INDEX_BITS-1:0] req_idx;
  logic [CTR_BITS-1:0]   rd_ctr;
  logic [CTR_BITS-1:0]   cur_ctr;
  logic [CTR_BITS-1:0]   ctr_d;
  logic                  hit;

  always_comb begin
    hist_ext = (HIST_BITS == 0) ? '0 : INDEX_BITS'(ghr_q);
    req_idx  = req_pc ^ hist_ext;
    rd_ctr   = tbl_q[req_idx];

    prediction_d = prediction_q;
    pred_index_d = pred_index_q;
    if (request) begin
      prediction_d = rd_ctr[CTR_BITS-1];
      pred_index_d = req_idx;
    end

    cur_ctr = tbl_q[upd_index];
    hit     = (cur_ctr[CTR_BITS-1] == taken);
    ctr_d   = cur_ctr;
    if (taken && (cur_ctr != '1)) begin
      ctr_d = cur_ctr + CTR_BITS'(1);
    end else if (!taken && (cur_ctr != '0)) begin
      ctr_d = cur_ctr - CTR_BITS'(1);
    end

    ghr_d = (HIST_BITS == 0) ? '0 : GW'({ghr_q, taken});

    upd_count_d = upd_count_q;
    if (upd_count_q != '1) begin
      upd_count_d = upd_count_q + STAT_BITS'(1);
    end
    hit_count_d = hit_count_q;
    if (hit && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + STAT_BITS'(1);
    end
  end

  // Prediction reads the pre-edge table and history, so a same-cycle update never bypasses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      prediction_q <= 1'b0;
      pred_index_q <= '0;
      ghr_q        <= '0;
      upd_count_q  <= '0;
      hit_count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= CTR_BITS'(INIT_CTR);
      end
    end else begin
      pred_valid_q <= request;
      prediction_q <= prediction_d;
      pred_index_q <= pred_index_d;
      if (update) begin
        tbl_q[upd_index] <= ctr_d;
        ghr_q            <= ghr_d;
        upd_count_q      <= upd_count_d;
        hit_count_q      <= hit_count_d;
      end
    end
  end

  assign pred_valid = pred_valid_q;
  assign prediction = prediction_q;
  assign pred_index = pred_index_q;
  assign upd_count  = upd_count_q;
  assign hit_count  = hit_count_q;

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 The module SHALL have parameter INDEX_BITS, default 4, giving log2 of the pattern-table depth.
REQ-002 The module SHALL have parameter HIST_BITS, default 4, giving the global-history length; legal range 0..INDEX_BITS.
REQ-003 The module SHALL have parameter CTR_BITS, default 2, giving the saturating-counter width; legal range 1..4.
REQ-004 The module SHALL have parameter INIT_CTR, default 1 (weakly not taken), giving the reset value of every counter.
REQ-005 The module SHALL have parameter STAT_BITS, default 16, giving the width of the statistics counters.
REQ-006 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-007 Port: clk  input  1  rising-edge clock.
REQ-008 Port: rst_n  input  1  asynchronous active-low reset.
REQ-009 Port: request  input  1  prediction request, sampled at posedge clk.
REQ-010 Port: req_pc  input  INDEX_BITS  branch address bits for the request.
REQ-011 Port: pred_valid  output  1  prediction valid, registered.
REQ-012 Port: prediction  output  1  predicted direction, 1 = taken, registered.
REQ-013 Port: pred_index  output  INDEX_BITS  table index used, returned on update.
REQ-014 Port: update  input  1  resolved-branch update strobe.
REQ-015 Port: upd_index  input  INDEX_BITS  table index to train.
REQ-016 Port: taken  input  1  resolved direction of the updated branch.
REQ-017 Port: upd_count  output  STAT_BITS  number of updates accepted.
REQ-018 Port: hit_count  output  STAT_BITS  number of updates whose pre-update counter MSB equalled taken.

Function
REQ-019 The table SHALL hold 2^INDEX_BITS counters of CTR_BITS, plus a HIST_BITS global history register (GHR).
REQ-020 Request index SHALL be req_pc XOR zero-extended GHR; with HIST_BITS=0 the index SHALL be req_pc (bimodal).
REQ-021 On a posedge with request=1, the next cycle SHALL present pred_valid=1, prediction=MSB of the indexed counter, and pred_index=computed index (latency 1).
REQ-022 On a posedge with request=0, pred_valid SHALL go to 0; prediction and pred_index SHALL hold their values.
REQ-023 On a posedge with update=1, counter[upd_index] SHALL increment when taken=1 and decrement when taken=0, saturating at 2^CTR_BITS-1 and 0.
REQ-024 On update, GHR SHALL shift left by one with taken entering bit 0; GHR SHALL not change on a request.
REQ-025 On update, upd_count SHALL increment; hit_count SHALL increment when the pre-update counter MSB equals taken; both SHALL saturate at 2^STAT_BITS-1.
REQ-026 When request and update occur in the same cycle, the prediction SHALL use the pre-update counter and the pre-update GHR, regardless of index collision.
REQ-027 Update with update=0 SHALL leave table, GHR and statistics unchanged.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock, force pred_valid=0, prediction=0, pred_index=0, upd_count=0, hit_count=0, GHR=0, and every counter=INIT_CTR.
REQ-029 While rst_n=0, request and update SHALL be ignored; the first effective edge SHALL be the first posedge after rst_n rises.

Verification
REQ-030 Reset, then request with req_pc=3 -> next cycle pred_valid=1, prediction=0, pred_index=3; following idle cycle pred_valid=0.
REQ-031 Two updates upd_index=5, taken=1 -> counter[5]=3, GHR=0b0011; then request req_pc=6 -> pred_index=5, prediction=1; third taken update -> counter[5] stays 3.
REQ-032 Reset, four updates upd_index=2, taken=0 -> counter[2] 1->0 and holds 0; upd_count=4, hit_count=4.
REQ-033 Counter[5]=1, GHR=0; same cycle request req_pc=5 and update upd_index=5, taken=1 -> prediction=0 (old value); next request at index 5 -> prediction=1.
REQ-034 rst_n driven low between clock edges while pred_valid=1 and upd_count=7 -> pred_valid=0 and upd_count=0 before the next edge; request afterwards -> prediction from INIT_CTR.
REQ-035 Instance with STAT_BITS=2: five correct updates -> upd_count=3, hit_count=3 (saturated, no wrap).
